// File: rtl/edge_log_sched_if.sv
// edge_log_sched_if: 8-bit pixel valid/ready stream with end-of-frame marker
interface edge_log_sched_if;
   logic       valid;
   logic       ready;
   logic [7:0] pixel;
   logic       last;
   modport master (output valid, output pixel, output last, input ready);
   modport slave (input valid, input pixel, output ready);
endinterface

// File: rtl/edge_log_sched.sv
// edge_log_sched: raster scheduler feeding a 5x5 LoG window; EDGE_LOG_BYPASS_EN adds a centre-pixel bypass input
module edge_log_sched #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   edge_log_sched_if.slave  s,
   output logic [199:0]     win_out,
   input  logic [7:0]       filt_pixel,
`ifdef EDGE_LOG_BYPASS_EN
   input  logic             bypass,
`endif
   edge_log_sched_if.master m
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
   state_t state, state_n;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0] lb [4][IMG_W];
   logic [7:0] win [5][5];
   logic win_vld, win_last, m_valid_r, m_last_r;
   logic [7:0] m_pixel_r;
   logic acc, cap, col_end, row_end, fin;
   assign col_end = col == CW'(IMG_W - 1);
   assign row_end = row == RW'(IMG_H - 1);
   assign busy = state != IDLE;
   // hold input only when a finished window is blocked behind an unaccepted output
   assign s.ready = busy && state != FLUSH && !(win_vld && m_valid_r && !m.ready);
   assign acc = s.valid && s.ready;
   assign cap = win_vld && (!m_valid_r || m.ready);
   assign fin = m_valid_r && m.ready && m_last_r;
   assign m.valid = m_valid_r;
   assign m.pixel = m_pixel_r;
   assign m.last = m_last_r;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = FILL;
         FILL:    if (acc && row == RW'(4) && col == CW'(3)) state_n = RUN;
         RUN:     if (acc && row_end && col_end) state_n = FLUSH;
         FLUSH:   if (fin) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst || (state == IDLE && start)) begin
         col <= '0;
         row <= '0;
         win_vld <= 1'b0;
         win_last <= 1'b0;
      end else if (acc) begin
         col <= col_end ? '0 : col + 1'b1;
         row <= col_end ? row + 1'b1 : row;
         win_vld <= row >= RW'(4) && col >= CW'(4);
         win_last <= row_end && col_end;
      end else if (cap) win_vld <= 1'b0;
   // lb[0] holds the oldest line, lb[3] the line just above the incoming pixel
   always_ff @(posedge clk)
      if (acc) begin
         for (int i = 0; i < 3; i++) lb[i][col] <= lb[i+1][col];
         lb[3][col] <= s.pixel;
      end
   always_ff @(posedge clk)
      if (rst) begin
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) win[i][j] <= '0;
      end else if (acc) begin
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4; j++) win[i][j] <= win[i][j+1];
         for (int i = 0; i < 4; i++) win[i][4] <= lb[i][col];
         win[4][4] <= s.pixel;
      end
   for (genvar i = 0; i < 5; i++) begin : g_r
      for (genvar j = 0; j < 5; j++) begin : g_c
         assign win_out[40*i + 8*j +: 8] = win[i][j];
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         m_valid_r <= 1'b0;
         m_last_r <= 1'b0;
         m_pixel_r <= '0;
      end else if (cap) begin
         m_valid_r <= 1'b1;
         m_last_r <= win_last;
`ifdef EDGE_LOG_BYPASS_EN
         m_pixel_r <= bypass ? win_out[103:96] : filt_pixel;
`else
         m_pixel_r <= filt_pixel;
`endif
      end else if (m.ready) begin
         m_valid_r <= 1'b0;
         m_last_r <= 1'b0;
      end
   always_ff @(posedge clk)
      done <= rst ? 1'b0 : state == FLUSH && fin;
endmodule

// File: tb/tb_edge_log_sched.sv
// tb_edge_log_sched: directed 8x8 frames through edge_log_sched with an attached LoG filter model
module tb_edge_log_sched;
   localparam int W = 8;
   localparam int H = 8;
   localparam int KER [25] = '{0, 0, -1, 0, 0, 0, -1, -2, -1, 0, -1, -2, 16, -2, -1, 0, -1, -2, -1, 0, 0, 0, -1, 0, 0};
   typedef struct {int pat; int gap; int rdy; bit mid; bit byp; int exp_n;} vec_t;
   logic clk = 0, rst = 1, start = 0, busy, done;
   logic [199:0] win_out;
   logic [7:0] filt_pixel;
`ifdef EDGE_LOG_BYPASS_EN
   logic bypass = 0;
`endif
   int total = 0, bad = 0, vnum = 0;
   logic [7:0] img [H][W];
   logic [7:0] q[$];
   logic lq[$];
   vec_t vecs[$];
   edge_log_sched_if s_if ();
   edge_log_sched_if m_if ();
   edge_log_sched #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .s(s_if),
      .win_out(win_out), .filt_pixel(filt_pixel),
`ifdef EDGE_LOG_BYPASS_EN
      .bypass(bypass),
`endif
      .m(m_if));
   always #5 clk = ~clk;
   function automatic logic [7:0] clamp8(input int v);
      return v < 0 ? 8'd0 : v > 255 ? 8'd255 : 8'(v);
   endfunction
   // filter: centre plus Laplacian-of-Gaussian response / 8, so flat and linear images pass unchanged
   function automatic logic [7:0] filt_fn(input logic [199:0] w);
      int a = 0;
      for (int i = 0; i < 25; i++) a += KER[i] * int'(w[8*i +: 8]);
      return clamp8(int'(w[103:96]) + a / 8);
   endfunction
   function automatic logic [7:0] gold(input int r, input int c);
      int a = 0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) a += KER[i*5 + j] * int'(img[r-2+i][c-2+j]);
      return clamp8(int'(img[r][c]) + a / 8);
   endfunction
   always_comb filt_pixel = filt_fn(win_out);
   task automatic check(input string name, input logic [199:0] act, input logic [199:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask
   task automatic fill_img(input int pat);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = pat == 0 ? 8'd50 : pat == 1 ? 8'(r*8 + c) : 8'($urandom_range(255));
   endtask
   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_s_ready"}, s_if.ready, 0);
      check({tag, "_m_valid"}, m_if.valid, 0);
      check({tag, "_m_last"}, m_if.last, 0);
      check({tag, "_m_pixel"}, m_if.pixel, 0);
      check({tag, "_win_out"}, win_out, 0);
   endtask
   task automatic feed(input int n, output int idx);
      start = 1;
      @(negedge clk);
      start = 0;
      idx = 0;
      m_if.ready = 1;
      for (int cyc = 0; cyc < 1000 && idx < n; cyc++) begin
         s_if.valid = 1;
         s_if.pixel = img[idx / W][idx % W];
         #1;
         if (s_if.ready) idx++;
         @(negedge clk);
      end
      s_if.valid = 0;
   endtask
   task automatic run_frame(input vec_t v);
      int idx = 0, dones = 0, last_hs = -1, done_at = -1;
      bit hold = 0;
      logic [7:0] held = 0;
      logic [7:0] want[$];
      logic [31:0] lmask = 0;
      fill_img(v.pat);
      for (int r = 2; r < H - 2; r++)
         for (int c = 2; c < W - 2; c++) want.push_back(v.byp ? img[r][c] : gold(r, c));
      q.delete();
      lq.delete();
`ifdef EDGE_LOG_BYPASS_EN
      bypass = v.byp;
`endif
      start = 1;
      @(negedge clk);
      start = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         s_if.valid = idx < W*H && $urandom_range(99) >= v.gap;
         s_if.pixel = s_if.valid ? img[idx / W][idx % W] : 8'h00;
         m_if.ready = $urandom_range(99) < v.rdy;
         start = v.mid && idx == 20;
         #1;
         if (hold) begin
            check($sformatf("v%0d_hold_valid", vnum), m_if.valid, 1);
            check($sformatf("v%0d_hold_pixel", vnum), m_if.pixel, held);
         end
         if (done) begin
            dones++;
            if (done_at < 0) begin
               done_at = cyc;
               check($sformatf("v%0d_busy_at_done", vnum), busy, 0);
            end
         end
         if (s_if.valid && s_if.ready) idx++;
         if (m_if.valid && m_if.ready) begin
            q.push_back(m_if.pixel);
            lq.push_back(m_if.last);
            last_hs = cyc;
         end
         hold = m_if.valid && !m_if.ready;
         held = m_if.pixel;
         if (done_at >= 0 && cyc >= done_at + 3) break;
         @(negedge clk);
      end
      s_if.valid = 0;
      m_if.ready = 0;
      start = 0;
      check($sformatf("v%0d_in_count", vnum), idx, W*H);
      check($sformatf("v%0d_out_count", vnum), q.size(), v.exp_n);
      for (int k = 0; k < q.size() && k < want.size(); k++)
         check($sformatf("v%0d_pix%0d", vnum, k), q[k], want[k]);
      for (int k = 0; k < lq.size() && k < 32; k++) lmask[k] = lq[k];
      check($sformatf("v%0d_m_last", vnum), lmask, 32'd1 << (v.exp_n - 1));
      check($sformatf("v%0d_done_cnt", vnum), dones, 1);
      check($sformatf("v%0d_done_lat", vnum), done_at, last_hs + 1);
      check($sformatf("v%0d_busy_end", vnum), busy, 0);
   endtask
   initial begin
      int n;
      logic [199:0] wwin;
      s_if.valid = 0;
      s_if.pixel = 0;
      s_if.last = 0;
      m_if.ready = 0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 0;
      // first complete window lands right after pixel (4,4) is accepted
      fill_img(1);
      feed(37, n);
      check("feed37", n, 37);
      check("win_tl", win_out[7:0], 0);
      check("win_centre", win_out[103:96], 18);
      check("win_br", win_out[199:192], 36);
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) wwin[8*(5*i + j) +: 8] = img[i][j];
      check("win_full", win_out, wwin);
      check("m_valid_latency", m_if.valid, 0);
      @(negedge clk);
      check("first_m_valid", m_if.valid, 1);
      check("first_m_pixel", m_if.pixel, gold(2, 2));
      rst = 1;
      @(negedge clk);
      check_reset_vals("rst_out");
      rst = 0;
      feed(30, n);
      check("feed30", n, 30);
      rst = 1;
      @(negedge clk);
      check_reset_vals("rst_mid");
      rst = 0;
      @(negedge clk);
      vecs.push_back('{0, 0, 100, 0, 0, 16});
      vecs.push_back('{1, 0, 100, 0, 0, 16});
      vecs.push_back('{1, 40, 50, 0, 0, 16});
      vecs.push_back('{2, 0, 100, 0, 0, 16});
      vecs.push_back('{2, 30, 60, 0, 0, 16});
      vecs.push_back('{0, 0, 100, 1, 0, 16});
`ifdef EDGE_LOG_BYPASS_EN
      vecs.push_back('{1, 0, 100, 0, 1, 16});
      vecs.push_back('{2, 25, 50, 0, 1, 16});
`endif
      for (int k = 0; k < vecs.size(); k++) begin
         vnum = k;
         run_frame(vecs[k]);
         @(negedge clk);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
